// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between control logic and the PS/2 host transmitter.
// master = control logic issuing commands, slave = ps2_host_tx.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic [1:0] tx_status;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, tx_done, tx_status
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, tx_done, tx_status
   );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out one byte plus odd parity on device clock falls and collects the ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 6000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic         clk,
   input  logic         reset,
   ps2_host_tx_if.slave tx,
   input  logic         ps2_clock_in,
   input  logic         ps2_data_in,
   output logic         ps2_clock_drive_low,
   output logic         ps2_data_drive_low,
   output logic         rx_block
);

   localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_ACK     = 2'b00;
   localparam logic [1:0] ST_NACK    = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQ,
      S_SEND,
      S_ACK,
      S_RELEASE
   } state_t;

   state_t state, state_nxt;

   logic clk_meta, clk_sync, clk_prev;
   logic dat_meta, dat_sync;
   logic fall;

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       bit_cnt, bit_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             parity, parity_nxt;
   logic [1:0]       ack_status, ack_nxt;

   logic clk_drv_q, clk_drv_nxt;
   logic dat_drv_q, dat_drv_nxt;
   logic ready_q, ready_nxt;
   logic block_q, block_nxt;
   logic done_q, done_nxt;
   logic [1:0] status_q, status_nxt;

   // Synchronizers preset high so reset release never looks like a clock fall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= ps2_clock_in;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         dat_meta <= ps2_data_in;
         dat_sync <= dat_meta;
      end
   end

   assign fall = clk_prev & ~clk_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         parity     <= 1'b0;
         ack_status <= ST_ACK;
         clk_drv_q  <= 1'b0;
         dat_drv_q  <= 1'b0;
         ready_q    <= 1'b1;
         block_q    <= 1'b0;
         done_q     <= 1'b0;
         status_q   <= ST_ACK;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         bit_cnt    <= bit_nxt;
         shift      <= shift_nxt;
         parity     <= parity_nxt;
         ack_status <= ack_nxt;
         clk_drv_q  <= clk_drv_nxt;
         dat_drv_q  <= dat_drv_nxt;
         ready_q    <= ready_nxt;
         block_q    <= block_nxt;
         done_q     <= done_nxt;
         status_q   <= status_nxt;
      end
   end

   // Counter defaults to zero, so any state change or fall clears it.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = '0;
      bit_nxt     = bit_cnt;
      shift_nxt   = shift;
      parity_nxt  = parity;
      ack_nxt     = ack_status;
      dat_drv_nxt = dat_drv_q;
      done_nxt    = 1'b0;
      status_nxt  = status_q;

      case (state)
         S_IDLE: begin
            dat_drv_nxt = 1'b0;
            if (tx.tx_valid && ready_q) begin
               state_nxt  = S_INHIBIT;
               shift_nxt  = tx.tx_data;
               parity_nxt = ~^tx.tx_data;
            end
         end
         S_INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
               state_nxt   = S_REQ;
               dat_drv_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_REQ: begin
            state_nxt = S_SEND;
            bit_nxt   = '0;
         end
         S_SEND: begin
            if (fall) begin
               bit_nxt = bit_cnt + 4'd1;
               if (bit_cnt < 4'd8) begin
                  dat_drv_nxt = ~shift[bit_cnt[2:0]];
               end else if (bit_cnt == 4'd8) begin
                  dat_drv_nxt = ~parity;
               end else begin
                  dat_drv_nxt = 1'b0;
                  state_nxt   = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (fall) begin
               bit_nxt   = bit_cnt + 4'd1;
               ack_nxt   = dat_sync ? ST_NACK : ST_ACK;
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (clk_sync && dat_sync) begin
               state_nxt  = S_IDLE;
               done_nxt   = 1'b1;
               status_nxt = ack_status;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if ((state == S_SEND || state == S_ACK || state == S_RELEASE) &&
          state_nxt == state && !fall) begin
         if (cnt == TIMEOUT_LAST) begin
            state_nxt   = S_IDLE;
            dat_drv_nxt = 1'b0;
            done_nxt    = 1'b1;
            status_nxt  = ST_TIMEOUT;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end

      clk_drv_nxt = (state_nxt == S_INHIBIT) || (state_nxt == S_REQ);
      ready_nxt   = (state_nxt == S_IDLE);
      block_nxt   = (state_nxt != S_IDLE);
   end

   assign ps2_clock_drive_low = clk_drv_q;
   assign ps2_data_drive_low  = dat_drv_q;
   assign rx_block            = block_q;
   assign tx.tx_ready         = ready_q;
   assign tx.tx_done          = done_q;
   assign tx.tx_status        = status_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device,
// frames predicted from the byte value and compared at device clock edges.
module tb_ps2_host_tx;
   localparam int unsigned INHIBIT = 50;
   localparam int unsigned TIMEOUT = 200;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;
   logic ps2_clock_in, ps2_data_in;
   logic clk_drv, dat_drv, rx_block;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [1:0] st;

   ps2_host_tx_if bus();

   ps2_host_tx #(
      .INHIBIT_CYCLES(INHIBIT),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .tx                  (bus),
      .ps2_clock_in        (ps2_clock_in),
      .ps2_data_in         (ps2_data_in),
      .ps2_clock_drive_low (clk_drv),
      .ps2_data_drive_low  (dat_drv),
      .rx_block            (rx_block)
   );

   // Wired-AND open-drain lines with pull-ups.
   assign ps2_clock_in = ~(clk_drv | dev_clk_low);
   assign ps2_data_in  = ~(dat_drv | dev_dat_low);

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Line level of frame position idx: 0 start, 1..8 data LSB first, 9 odd parity, 10 stop.
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      int v;
      int ones;
      v = int'(b);
      ones = 0;
      for (int k = 0; k < 8; k++) ones += (v >> k) & 1;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return 1'(((v >> (idx - 1)) & 1) != 0);
      if (idx == 9) return 1'((ones % 2) == 0);
      return 1'b1;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit ack, input int half,
                            input bit poke, input bit abort, output logic [1:0] status);
      int n;
      int dat_rise;
      bit seen;
      logic lvl [0:10];
      logic exp_drv;
      logic prev_drv;
      status = 2'b11;
      check("ready_before", 32'(bus.tx_ready), 32'd1);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
      check("accept_clk_low", 32'(clk_drv), 32'd1);
      check("accept_ready", 32'(bus.tx_ready), 32'd0);
      check("accept_block", 32'(rx_block), 32'd1);
      check("done_width", 32'(bus.tx_done), 32'd0);

      n = 0;
      dat_rise = 0;
      while (clk_drv && n < int'(INHIBIT) + 100) begin
         n++;
         if (dat_drv && dat_rise == 0) dat_rise = n;
         if (poke && n == 10) begin
            bus.tx_data  = ~b;
            bus.tx_valid = 1'b1;
         end
         if (poke && n == 11) bus.tx_valid = 1'b0;
         tick();
      end
      check("clk_low_cycles", 32'(n), 32'(INHIBIT + 1));
      check("req_data_cycle", 32'(dat_rise), 32'(INHIBIT + 1));

      repeat (3) tick();
      lvl[0] = ps2_data_in;
      prev_drv = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         if (i == 11) begin
            dev_dat_low = ack;
            repeat (3) tick();
         end
         dev_clk_low = 1'b1;
         tick();
         tick();
         if (i <= 10) check($sformatf("drv_hold_%0d", i), 32'(dat_drv), 32'(prev_drv));
         tick();
         if (i <= 10) begin
            exp_drv = ~frame_bit(b, i);
            check($sformatf("drv_latency_%0d", i), 32'(dat_drv), 32'(exp_drv));
            prev_drv = exp_drv;
         end
         if (abort && i == 4) begin
            reset = 1'b0;
            #1;
            check("abort_clk_rel", 32'(clk_drv), 32'd0);
            check("abort_dat_rel", 32'(dat_drv), 32'd0);
            check("abort_no_done", 32'(bus.tx_done), 32'd0);
            check("abort_ready", 32'(bus.tx_ready), 32'd1);
            check("abort_block", 32'(rx_block), 32'd0);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            repeat (3) tick();
            reset = 1'b1;
            seen = 1'b0;
            repeat (30) begin
               tick();
               if (bus.tx_done || clk_drv) seen = 1'b1;
            end
            check("abort_quiet", 32'(seen), 32'd0);
            return;
         end
         repeat (half - 3) tick();
         dev_clk_low = 1'b0;
         if (i <= 10) lvl[i] = ps2_data_in;
         if (i < 11) repeat (half) tick();
      end
      dev_dat_low = 1'b0;

      for (int i = 0; i <= 10; i++)
         check($sformatf("frame_%0d", i), 32'(lvl[i]), 32'(frame_bit(b, i)));

      n = 0;
      while (!bus.tx_done && n < 200) begin
         tick();
         n++;
      end
      check("done_seen", 32'(bus.tx_done), 32'd1);
      check("status", 32'(bus.tx_status), ack ? 32'd0 : 32'd1);
      check("done_clk_rel", 32'(clk_drv), 32'd0);
      check("done_dat_rel", 32'(dat_drv), 32'd0);
      check("done_ready", 32'(bus.tx_ready), 32'd1);
      check("done_block", 32'(rx_block), 32'd0);
      status = bus.tx_status;
   endtask

   task automatic timeout_run(input logic [7:0] b);
      int n;
      check("to_ready_before", 32'(bus.tx_ready), 32'd1);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      tick();
      bus.tx_valid = 1'b0;
      n = 0;
      while (clk_drv && n < int'(INHIBIT) + 100) begin
         n++;
         tick();
      end
      check("to_clk_low_cycles", 32'(n), 32'(INHIBIT + 1));
      n = 1;
      while (!bus.tx_done && n < 1000) begin
         tick();
         n++;
      end
      check("to_done_cycle", 32'(n), 32'(TIMEOUT + 1));
      check("to_status", 32'(bus.tx_status), 32'd2);
      check("to_clk_rel", 32'(clk_drv), 32'd0);
      check("to_dat_rel", 32'(dat_drv), 32'd0);
      check("to_ready", 32'(bus.tx_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'hED;
      reset = 1'b0;
      repeat (5) tick();
      check("rst_ready", 32'(bus.tx_ready), 32'd1);
      check("rst_clk_drv", 32'(clk_drv), 32'd0);
      check("rst_dat_drv", 32'(dat_drv), 32'd0);
      check("rst_block", 32'(rx_block), 32'd0);
      check("rst_done", 32'(bus.tx_done), 32'd0);
      check("rst_status", 32'(bus.tx_status), 32'd0);
      bus.tx_valid = 1'b0;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      check("post_rst_ready", 32'(bus.tx_ready), 32'd1);
      check("post_rst_idle", 32'(clk_drv), 32'd0);

      send_byte(8'hED, 1'b1, 20, 1'b1, 1'b0, st);
      repeat (10) tick();
      check("poke_not_queued", 32'(clk_drv), 32'd0);
      check("poke_ready", 32'(bus.tx_ready), 32'd1);

      send_byte(8'hF4, 1'b1, 20, 1'b0, 1'b0, st);
      send_byte(8'hED, 1'b1, 20, 1'b0, 1'b0, st);
      repeat (4) tick();

      send_byte(8'($urandom), 1'b0, 16, 1'b0, 1'b0, st);
      repeat (4) tick();

      timeout_run(8'hA5);
      repeat (4) tick();

      send_byte(8'hF4, 1'b1, 20, 1'b0, 1'b1, st);
      send_byte(8'hF4, 1'b1, 20, 1'b0, 1'b0, st);

      for (int r = 0; r < 6; r++) begin
         send_byte(8'($urandom), ($urandom_range(0, 4) != 0), int'($urandom_range(8, 24)),
                   1'($urandom_range(0, 1)), 1'b0, st);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
